// File: rtl/vxe_vpu_lsu_wrq.sv
// Store-unit write queue: request FIFO feeding a registered memory-request stage, with an outstanding-write
// counter (credit limit) and a sticky error flag. Latency 2 cycles. Upstream is stalled only when the FIFO is full.
module vxe_vpu_lsu_wrq #(
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_wrq_wr,
    input  logic [2:0]  i_wrq_th,
    input  logic [36:0] i_wrq_addr,
    input  logic [1:0]  i_wrq_wen,
    input  logic [63:0] i_wrq_data,
    output logic        o_wrq_rdy,
    output logic        o_mrq_valid,
    input  logic        i_mrq_rdy,
    output logic [2:0]  o_mrq_th,
    output logic [36:0] o_mrq_addr,
    output logic [1:0]  o_mrq_wen,
    output logic [63:0] o_mrq_data,
    input  logic        i_mrs_valid,
    input  logic        i_mrs_err,
    input  logic        i_err_clr,
    output logic        o_err,
    output logic        o_busy
);
    localparam int L = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << L;
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [2:0]  th;
        logic [36:0] addr;
        logic [1:0]  wen;
        logic [63:0] data;
    } wrq_t;

    wrq_t         mem [DEPTH];
    logic [L:0]   wptr;
    logic [L:0]   rptr;
    logic [3:0]   cnt;
    logic         fifo_empty;
    logic         fifo_full;
    logic         push;
    logic         load_ok;
    logic         load;
    logic         err_set;
    wrq_t         head;

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[L-1:0] == rptr[L-1:0]) && (wptr[L] != rptr[L]);
    assign o_wrq_rdy  = !fifo_full;

    // Requests with no word enabled are acknowledged but never reach memory.
    assign push    = i_wrq_wr && o_wrq_rdy && (i_wrq_wen != 2'b00);
    assign load_ok = (!o_mrq_valid || i_mrq_rdy) && ((cnt < MAX_CNT) || i_mrs_valid);
    assign load    = !fifo_empty && load_ok;
    assign head    = mem[rptr[L-1:0]];

    // A response with nothing outstanding is a protocol error; the counter saturates at 0.
    assign err_set = i_mrs_valid && (i_mrs_err || ((cnt == 4'd0) && !load));
    assign o_busy  = !fifo_empty || o_mrq_valid || (cnt != 4'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[L-1:0]] <= '{th: i_wrq_th, addr: i_wrq_addr, wen: i_wrq_wen, data: i_wrq_data};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr        <= '0;
            rptr        <= '0;
            cnt         <= 4'd0;
            o_err       <= 1'b0;
            o_mrq_valid <= 1'b0;
            o_mrq_th    <= '0;
            o_mrq_addr  <= '0;
            o_mrq_wen   <= '0;
            o_mrq_data  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (load) begin
                rptr        <= rptr + 1'b1;
                o_mrq_valid <= 1'b1;
                o_mrq_th    <= head.th;
                o_mrq_addr  <= head.addr;
                o_mrq_wen   <= head.wen;
                o_mrq_data  <= head.data;
            end else if (i_mrq_rdy) begin
                o_mrq_valid <= 1'b0;
            end

            if (load && !i_mrs_valid) begin
                cnt <= cnt + 4'd1;
            end else if (!load && i_mrs_valid && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            if (err_set) begin
                o_err <= 1'b1;
            end else if (i_err_clr) begin
                o_err <= 1'b0;
            end
        end
    end
endmodule

// File: doc/vxe_vpu_lsu_wrq.md
VXE_VPU_LSU_WRQ -- requirements
Module: vxe_vpu_lsu_wrq

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  FIFO_DEPTH_LOG2  2  log2 of the request FIFO depth (4 entries).
  MAX_OUTSTANDING  8  maximum number of reserved but unanswered memory writes (1..15).
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  clk  in  1  clock.
  nrst  in  1  asynchronous active-low reset.
  i_wrq_wr  in  1  store unit request valid, held until accepted.
  i_wrq_th  in  3  thread id.
  i_wrq_addr  in  37  64-bit word address.
  i_wrq_wen  in  2  word enables: [0] low word, [1] high word.
  i_wrq_data  in  64  write data: {hi, lo}.
  o_wrq_rdy  out  1  request accepted this cycle if i_wrq_wr=1.
  o_mrq_valid  out  1  memory write request valid.
  i_mrq_rdy  in  1  memory accepts request.
  o_mrq_th  out  3  thread id tag.
  o_mrq_addr  out  37  word address.
  o_mrq_wen  out  2  word enables.
  o_mrq_data  out  64  write data.
  i_mrs_valid  in  1  one write response.
  i_mrs_err  in  1  response carries an error (qualified by i_mrs_valid).
  i_err_clr  in  1  clears o_err.
  o_err  out  1  sticky error flag.
  o_busy  out  1  FIFO non-empty, output register valid, or any write outstanding.
REQ-003 SHALL use clock clk and reset nrst, asynchronous, active-low.

Function
REQ-004 SHALL accept a request on a cycle where i_wrq_wr && o_wrq_rdy; o_wrq_rdy = !fifo_full, combinational, with no dependency on i_wrq_wr.
REQ-005 SHALL store accepted requests in a FIFO of 2^FIFO_DEPTH_LOG2 entries, using wrap-bit pointers: empty when the pointers are equal; full when the index bits are equal and the wrap bits differ.
REQ-006 SHALL drop any request with i_wrq_wen=2'b00: it is accepted, not pushed, and not issued.
REQ-007 SHALL hold o_mrq_* in a registered output stage; o_mrq_valid=1 SHALL keep all o_mrq_* stable until i_mrq_rdy=1.
REQ-008 SHALL load the output stage from the FIFO head (pop) when the FIFO is non-empty and load_ok holds.
  load_ok = (!o_mrq_valid || i_mrq_rdy) && (cnt < MAX_OUTSTANDING || i_mrs_valid).
REQ-009 SHALL give a latency of 2 cycles: a request accepted at edge k appears on o_mrq_* after edge k+1, when the FIFO was empty, cnt < MAX, and the output stage was free.
REQ-010 SHALL sustain 1 request/cycle when i_mrq_rdy=1 and cnt < MAX.
REQ-011 SHALL clear o_mrq_valid on i_mrq_rdy when no load occurs in the same cycle.
REQ-012 SHALL maintain outstanding counter cnt (4 bits):
  - +1 on output-stage load;
  - -1 on i_mrs_valid;
  - unchanged when both occur in the same cycle.
REQ-013 SHALL, when i_mrs_valid=1 with cnt=0 and no load that cycle, leave cnt at 0 and set o_err.
REQ-014 SHALL set o_err on i_mrs_valid && i_mrs_err.
REQ-015 SHALL clear o_err on i_err_clr; a set event in the same cycle as i_err_clr wins.
REQ-016 SHALL allow push and pop in the same cycle when full: o_wrq_rdy stays 0 that cycle, and the freed slot is visible next cycle.
REQ-017 SHALL drive o_busy = !fifo_empty || o_mrq_valid || (cnt != 0), combinational.
REQ-018 SHALL preserve request order end to end; no write combining.

Reset
REQ-019 SHALL, on nrst=0, asynchronously clear: FIFO pointers, cnt, o_mrq_valid, and o_err.
  - o_wrq_rdy=1 and o_busy=0 after reset.
  - o_mrq_th, o_mrq_addr, o_mrq_wen and o_mrq_data reset to 0.
REQ-020 SHALL, on reset mid-operation, discard all queued and outstanding requests; responses arriving after reset SHALL follow REQ-013.

Verification
REQ-021 Single write: wr th=2, addr=0x10, wen=01, data=0x0000_0000_1234_5678, with mrq_rdy=1 and one response 3 cycles later -> o_mrq_valid high after edge k+1 with the same fields; cnt goes 1 then 0; o_busy low after the response.
REQ-022 Back-pressure: mrq_rdy=0 and 6 back-to-back wr -> 5 accepted (4 FIFO + 1 output register), o_wrq_rdy=0 on the 6th; after mrq_rdy=1 all issue in order, 1/cycle.
REQ-023 Credit limit: MAX_OUTSTANDING=8, mrq_rdy=1, no responses, 10 writes -> exactly 8 loads; o_mrq_valid stays 0 afterwards. One response -> 9th load in the same cycle, and cnt stays 8.
REQ-024 Errors: a response with mrs_err=1 -> o_err=1 the next cycle. A response with cnt=0 -> o_err=1. i_err_clr together with a new error -> o_err stays 1.
REQ-025 Reset mid-stream: assert nrst=0 with 3 queued and 2 outstanding -> o_mrq_valid=0, o_busy=0, o_err=0, o_wrq_rdy=1 immediately.
REQ-026 wen=00 request -> accepted (o_wrq_rdy=1), no o_mrq_valid generated, cnt unchanged.
